// File: rtl/seq_comparator_pkg.sv
// ============================================================================
// Module   : cmp_pkg
// Purpose  : Shared types and sizing helpers for seq_comparator.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cmp_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } cmp_state_e;

    function automatic int unsigned cmp_nchunk(input int unsigned width,
                                               input int unsigned chunk);
        return width / chunk;
    endfunction

    // Index register needs at least one bit even when NCHUNK == 1.
    function automatic int unsigned cmp_idx_w(input int unsigned nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage : cmp_pkg

`default_nettype wire

// File: rtl/seq_comparator_if.sv
// ============================================================================
// Module   : seq_comparator_if
// Purpose  : Start/done request interface of the sliced magnitude comparator.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface seq_comparator_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_cmp;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;
    logic             gte;
    logic             lte;

    modport master (
        output start, a, b, signed_cmp,
        input  busy, done, eq, gt, lt, gte, lte
    );

    modport slave (
        input  start, a, b, signed_cmp,
        output busy, done, eq, gt, lt, gte, lte
    );

endinterface : seq_comparator_if

`default_nettype wire

// File: rtl/seq_comparator_slice.sv
// ============================================================================
// Module   : cmp_slice
// Purpose  : Combinational unsigned compare of one CHUNK-bit operand slice.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cmp_slice #(
    parameter int CHUNK = 8
) (
    input  wire logic [CHUNK-1:0] a_i,
    input  wire logic [CHUNK-1:0] b_i,
    output logic                  slice_gt_o,
    output logic                  slice_lt_o
);

    assign slice_gt_o = (a_i > b_i);
    assign slice_lt_o = (a_i < b_i);

endmodule : cmp_slice

`default_nettype wire

// File: rtl/seq_comparator.sv
// ============================================================================
// Module   : seq_comparator
// Purpose  : Multi-cycle signed/unsigned magnitude comparator, MSB slice first.
//            Define CMP_EARLY_EXIT_EN to stop on the first differing slice.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    seq_comparator_if.slave  bus
);

    localparam int unsigned      NCHUNK   = cmp_nchunk(WIDTH, CHUNK);
    localparam int unsigned      IDX_W    = cmp_idx_w(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    cmp_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             decided_q, gt_q, lt_q;
    logic             done_q;
    logic             res_eq_q, res_gt_q, res_lt_q, res_gte_q, res_lte_q;

    logic             accept;
    logic             complete;
    logic             last_slice;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [CHUNK-1:0] slice_a, slice_b;
    logic             slice_gt, slice_lt;
    logic             decided_nxt, gt_nxt, lt_nxt;
    logic             busy;

    assign accept   = (state_q == IDLE) && bus.start;
    assign complete = (state_q == SCAN) && last_slice;

    assign a_sh    = a_q >> (int'(idx_q) * CHUNK);
    assign b_sh    = b_q >> (int'(idx_q) * CHUNK);
    assign slice_a = a_sh[CHUNK-1:0];
    assign slice_b = b_sh[CHUNK-1:0];

    cmp_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a_i        (slice_a),
        .b_i        (slice_b),
        .slice_gt_o (slice_gt),
        .slice_lt_o (slice_lt)
    );

    // Once a higher slice has decided, lower slices are ignored.
    assign decided_nxt = decided_q | slice_gt | slice_lt;
    assign gt_nxt      = decided_q ? gt_q : slice_gt;
    assign lt_nxt      = decided_q ? lt_q : slice_lt;

`ifdef CMP_EARLY_EXIT_EN
    // With early exit nothing is ever decided while still scanning.
    assign last_slice = (idx_q == '0) || slice_gt || slice_lt;
`else
    assign last_slice = (idx_q == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start)  state_d = SCAN;
            SCAN:    if (last_slice) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SCAN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            done_q    <= 1'b0;
            res_eq_q  <= 1'b0;
            res_gt_q  <= 1'b0;
            res_lt_q  <= 1'b0;
            res_gte_q <= 1'b0;
            res_lte_q <= 1'b0;
        end else begin
            done_q <= complete;
            if (accept) begin
                // Flipping the sign bit maps two's complement onto unsigned order.
                a_q       <= bus.a ^ (bus.signed_cmp ? MSB_MASK : '0);
                b_q       <= bus.b ^ (bus.signed_cmp ? MSB_MASK : '0);
                idx_q     <= LAST_IDX;
                decided_q <= 1'b0;
                gt_q      <= 1'b0;
                lt_q      <= 1'b0;
            end else if (state_q == SCAN) begin
                decided_q <= decided_nxt;
                gt_q      <= gt_nxt;
                lt_q      <= lt_nxt;
                if (!last_slice) begin
                    idx_q <= idx_q - IDX_W'(1);
                end
            end
            if (complete) begin
                res_eq_q  <= !decided_nxt;
                res_gt_q  <= gt_nxt;
                res_lt_q  <= lt_nxt;
                res_gte_q <= !decided_nxt | gt_nxt;
                res_lte_q <= !decided_nxt | lt_nxt;
            end
        end
    end

    assign bus.busy = busy;
    assign bus.done = done_q;
    assign bus.eq   = res_eq_q;
    assign bus.gt   = res_gt_q;
    assign bus.lt   = res_lt_q;
    assign bus.gte  = res_gte_q;
    assign bus.lte  = res_lte_q;

endmodule : seq_comparator

`default_nettype wire

// File: tb/tb_seq_comparator.sv
// ============================================================================
// Module   : tb_seq_comparator
// Purpose  : Directed self-checking bench for seq_comparator (WIDTH=32, CHUNK=8).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_comparator;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;

    // Flag vectors ordered {eq, gt, lt, gte, lte}.
    localparam logic [4:0] F_ZERO = 5'b00000;
    localparam logic [4:0] F_EQ   = 5'b10011;
    localparam logic [4:0] F_GT   = 5'b01010;
    localparam logic [4:0] F_LT   = 5'b00101;

`ifdef CMP_EARLY_EXIT_EN
    localparam int MSB_DIFF_LAT = 1;
`else
    localparam int MSB_DIFF_LAT = 4;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    seq_comparator_if #(.WIDTH(WIDTH)) bus ();

    seq_comparator #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] flags();
        return {bus.eq, bus.gt, bus.lt, bus.gte, bus.lte};
    endfunction

    task automatic run_cmp(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [4:0] exp_f, input int exp_lat);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.a          = a;
        bus.b          = b;
        bus.signed_cmp = s;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, "/busy_rise"}, 32'(bus.busy), 32'd1);
        while (n < 20 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            seen = bus.done;
        end
        check({tag, "/latency"}, 32'(n), 32'(exp_lat));
        check({tag, "/flags"}, 32'(flags()), 32'(exp_f));
        check({tag, "/busy_fall"}, 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "/done_1cyc"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int ndone;
        int first_lat;
        int last_cyc;
        int dbl;
        logic [4:0] first_f;
        logic prev_done;

        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.signed_cmp = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset/flags", 32'(flags()), 32'(F_ZERO));
        check("reset/busy",  32'(bus.busy), 32'd0);
        check("reset/done",  32'(bus.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_cmp("eq_u",     32'h12345678, 32'h12345678, 1'b0, F_EQ, 4);
        run_cmp("msb_u",    32'h80000000, 32'h00000001, 1'b0, F_GT, MSB_DIFF_LAT);
        run_cmp("msb_s",    32'h80000000, 32'h00000001, 1'b1, F_LT, MSB_DIFF_LAT);
        run_cmp("lsb_s",    32'h000000FF, 32'h000000FE, 1'b1, F_GT, 4);

        // Second start while busy must be dropped.
        ndone = 0; first_lat = 0; first_f = F_ZERO;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'd5; bus.b = 32'd9; bus.signed_cmp = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'd9; bus.b = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        for (int n = 2; n <= 12; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                ndone++;
                if (ndone == 1) begin
                    first_lat = n;
                    first_f   = flags();
                end
            end
        end
        check("busy_start/ndone",   32'(ndone), 32'd1);
        check("busy_start/latency", 32'(first_lat), 32'd4);
        check("busy_start/flags",   32'(first_f), 32'(F_LT));

        // Reset during the third scan cycle aborts without a done pulse.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'd1; bus.b = 32'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort/flags", 32'(flags()), 32'(F_ZERO));
        check("abort/busy",  32'(bus.busy), 32'd0);
        check("abort/done",  32'(bus.done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        check("abort/no_done", 32'(ndone), 32'd0);
        run_cmp("post_rst", 32'd0, 32'd0, 1'b0, F_EQ, 4);

        // start held high: one compare every five cycles, operands alternate.
        ndone = 0; last_cyc = 0; dbl = 0; prev_done = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'd1; bus.b = 32'd2; bus.signed_cmp = 1'b0;
        for (int cyc = 1; cyc <= 30 && ndone < 3; cyc++) begin
            @(posedge clk);
            #1;
            if (bus.done && prev_done) dbl++;
            prev_done = bus.done;
            if (bus.done) begin
                check($sformatf("b2b%0d/period", ndone), 32'(cyc - last_cyc), 32'd5);
                check($sformatf("b2b%0d/flags", ndone), 32'(flags()),
                      32'((ndone % 2 == 0) ? F_LT : F_GT));
                last_cyc = cyc;
                ndone++;
                @(negedge clk);
                if (ndone == 3) begin
                    bus.start = 1'b0;
                end else if (ndone % 2 == 1) begin
                    bus.a = 32'd2; bus.b = 32'd1;
                end else begin
                    bus.a = 32'd1; bus.b = 32'd2;
                end
            end
        end
        bus.start = 1'b0;
        check("b2b/ndone",       32'(ndone), 32'd3);
        check("b2b/double_done", 32'(dbl), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seq_comparator

`default_nettype wire
